modmul_serial: RTL and testbench

- Parametrised bit-serial interleaved modular multiplier: computes result = (a * b) mod m, consuming one bit of b per clock, MSB first.
- Successor to the fixed 256-bit shift/double/add datapath, which hardwired p and relied on a load-clear. Adds a runtime modulus, generic WIDTH, a start/busy/done handshake and a bit counter.
- Sits under the ECC point-arithmetic controller as its field-multiply primitive.

---
 rtl/modmul_serial.sv | 117 +++++++++++
 tb/tb_modmul_serial.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/modmul_serial.sv
// ============================================================================
// Module   : modmul_serial
// Purpose  : Bit-serial interleaved modular multiplier, result = (a*b) mod m,
//            one multiplier bit per clock, MSB first, runtime modulus.
//            Optional operand-error flag enabled by macro MODMUL_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module modmul_serial #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_p;
  logic [CW-1:0]    r_cnt;
  logic             w_accept;

  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_dbl;
  logic [WIDTH:0]   w_dbl_red;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_p_nxt;

  assign w_accept = start && (r_state != c_run);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_idle;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (start) w_state_nxt = c_run;
      c_run:   if (r_cnt == '0) w_state_nxt = c_done;
      c_done:  w_state_nxt = start ? c_run : c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (r_state == c_run);
    done = (r_state == c_done);
  end

  // One interleaved step: P' = (2P mod m + b[i]*a) mod m, all at WIDTH+1 bits
  always_comb begin
    w_m_ext   = {1'b0, r_m};
    w_dbl     = {r_p, 1'b0};
    w_dbl_red = (w_dbl >= w_m_ext) ? (w_dbl - w_m_ext) : w_dbl;
    w_sum     = w_dbl_red + (r_b[r_cnt] ? {1'b0, r_a} : '0);
    w_p_nxt   = WIDTH'((w_sum >= w_m_ext) ? (w_sum - w_m_ext) : w_sum);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_m    <= '0;
      r_p    <= '0;
      r_cnt  <= '0;
      result <= '0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_m   <= m;
      r_p   <= '0;
      r_cnt <= c_last;
    end else if (r_state == c_run) begin
      r_p <= w_p_nxt;
      if (r_cnt == '0) result <= w_p_nxt;
      else             r_cnt  <= r_cnt - CW'(1);
    end
  end

`ifdef MODMUL_ERR_EN
  logic r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_err <= 1'b0;
    else if (w_accept) r_err <= (a >= m) || (m < WIDTH'(2));
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_modmul_serial.sv
// Testbench for modmul_serial: table vectors, handshake corner cases and
// randomized operands against an arithmetic (a*b) mod m reference.
`default_nettype none

module tb_modmul_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, m8 = '0;
  logic       busy8, done8, err8;
  logic [7:0] res8;

  logic         start256 = 1'b0;
  logic [255:0] a256 = '0, b256 = '0, m256 = '0;
  logic         busy256, done256, err256;
  logic [255:0] res256;

  int total = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  modmul_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .m(m8),
    .busy(busy8), .done(done8), .result(res8), .err(err8)
  );

  modmul_serial #(.WIDTH(256)) dut256 (
    .clk(clk), .rst(rst), .start(start256), .a(a256), .b(b256), .m(m256),
    .busy(busy256), .done(done256), .result(res256), .err(err256)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] m;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    else pass_cnt++;
  endtask

  function automatic bit exp_err(input logic [7:0] a, input logic [7:0] m);
`ifdef MODMUL_ERR_EN
    return (a >= m) || (m < 8'd2);
`else
    return 1'b0;
`endif
  endfunction

  // From a negedge inside (or just before) a run: count busy cycles, then sample done.
  task automatic wait8(output int bcnt, output bit dn);
    bcnt = 0;
    dn   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (busy8) bcnt++;
      else begin
        dn = done8;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                     output logic [7:0] res, output int bcnt, output bit dn);
    @(negedge clk);
    a8 = a; b8 = b; m8 = m; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait8(bcnt, dn);
    res = res8;
  endtask

  task automatic op256(input logic [255:0] a, input logic [255:0] b, input logic [255:0] m,
                       output logic [255:0] res, output int bcnt, output bit dn);
    @(negedge clk);
    a256 = a; b256 = b; m256 = m; start256 = 1'b1;
    @(negedge clk);
    start256 = 1'b0;
    bcnt = 0;
    dn   = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (busy256) bcnt++;
      else begin
        dn = done256;
        break;
      end
      @(negedge clk);
    end
    res = res256;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    vec_t       tbl[8];
    logic [7:0] r;
    logic [255:0] r256, ra, rb, rm;
    logic [511:0] prod;
    int         bc;
    bit         dn;
    int         seen;

    tbl[0] = '{8'd200, 8'd100, 8'd251, 8'd171};
    tbl[1] = '{8'd250, 8'd255, 8'd251, 8'd247};
    tbl[2] = '{8'd2,   8'd3,   8'd251, 8'd6};
    tbl[3] = '{8'd0,   8'd77,  8'd251, 8'd0};
    tbl[4] = '{8'd250, 8'd250, 8'd251, 8'd1};
    tbl[5] = '{8'd1,   8'd255, 8'd2,   8'd1};
    tbl[6] = '{8'd150, 8'd0,   8'd251, 8'd0};
    tbl[7] = '{8'd254, 8'd254, 8'd255, 8'd1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy8", 256'(busy8), 256'd0);
    chk("rst_done8", 256'(done8), 256'd0);
    chk("rst_res8", 256'(res8), 256'd0);
    chk("rst_err8", 256'(err8), 256'd0);
    chk("rst_res256", res256, 256'd0);
    chk("rst_busy256", 256'(busy256), 256'd0);
    rst = 1'b0;

    // Table vectors
    foreach (tbl[i]) begin
      op8(tbl[i].a, tbl[i].b, tbl[i].m, r, bc, dn);
      chk($sformatf("tbl%0d_res", i), 256'(r), 256'(tbl[i].exp));
      chk($sformatf("tbl%0d_busy", i), 256'(bc), 256'd8);
      chk($sformatf("tbl%0d_done", i), 256'(dn), 256'd1);
    end

    // done is a single-cycle pulse and result holds afterwards
    op8(8'd200, 8'd100, 8'd251, r, bc, dn);
    @(negedge clk);
    chk("done_one_cycle", 256'(done8), 256'd0);
    chk("result_hold", 256'(res8), 256'd171);

    // Back-to-back start during the DONE cycle
    op8(8'd250, 8'd255, 8'd251, r, bc, dn);
    chk("b2b_first_res", 256'(r), 256'd247);
    chk("b2b_first_done", 256'(dn), 256'd1);
    a8 = 8'd2; b8 = 8'd3; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("b2b_busy_next", 256'(busy8), 256'd1);
    chk("b2b_res_held", 256'(res8), 256'd247);
    wait8(bc, dn);
    chk("b2b_second_busy", 256'(bc), 256'd8);
    chk("b2b_second_done", 256'(dn), 256'd1);
    chk("b2b_second_res", 256'(res8), 256'd6);

    // Start pulsed mid-run must be ignored
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd100; m8 = 8'd251; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrun_busy", 256'(busy8), 256'd1);
    a8 = 8'd5; b8 = 8'd5; m8 = 8'd7; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait8(bc, dn);
    chk("midrun_remaining_busy", 256'(bc), 256'd4);
    chk("midrun_done", 256'(dn), 256'd1);
    chk("midrun_res", 256'(res8), 256'd171);

    // Asynchronous reset mid-run
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd9; m8 = 8'd11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_busy", 256'(busy8), 256'd0);
    chk("arst_done", 256'(done8), 256'd0);
    chk("arst_res", 256'(res8), 256'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 || busy8) seen++;
    end
    chk("arst_no_done", 256'(seen), 256'd0);
    op8(8'd200, 8'd100, 8'd251, r, bc, dn);
    chk("arst_fresh_res", 256'(r), 256'd171);

    // Operand error flag
    op8(8'd9, 8'd3, 8'd7, r, bc, dn);
    chk("err_bad_a", 256'(err8), 256'(exp_err(8'd9, 8'd7)));
    chk("err_bad_done", 256'(dn), 256'd1);
    @(negedge clk);
    chk("err_hold", 256'(err8), 256'(exp_err(8'd9, 8'd7)));
    op8(8'd3, 8'd3, 8'd7, r, bc, dn);
    chk("err_clear", 256'(err8), 256'd0);
    chk("err_clear_res", 256'(r), 256'd2);
    op8(8'd0, 8'd5, 8'd1, r, bc, dn);
    chk("err_small_m", 256'(err8), 256'(exp_err(8'd0, 8'd1)));
    chk("err_small_m_busy", 256'(bc), 256'd8);

    // Randomized WIDTH=8 against arithmetic model
    for (int n = 0; n < 30; n++) begin
      logic [7:0] ma, mb, mm;
      int exp;
      mm  = 8'($urandom_range(255, 2));
      ma  = 8'($urandom_range(int'(mm) - 1, 0));
      mb  = 8'($urandom_range(255, 0));
      exp = (int'(ma) * int'(mb)) % int'(mm);
      op8(ma, mb, mm, r, bc, dn);
      chk($sformatf("rnd8_%0d a=%0d b=%0d m=%0d", n, ma, mb, mm), 256'(r), 256'(exp));
      chk($sformatf("rnd8_%0d_busy", n), 256'(bc), 256'd8);
    end

    // WIDTH=256 directed
    op256(256'd3, 256'd4, 256'd7, r256, bc, dn);
    chk("w256_3x4", r256, 256'd5);
    chk("w256_busy", 256'(bc), 256'd256);
    chk("w256_done", 256'(dn), 256'd1);
    op256(256'd5, 256'd6, 256'd7, r256, bc, dn);
    chk("w256_5x6", r256, 256'd2);
    op256(256'd0, rand256(), 256'd7, r256, bc, dn);
    chk("w256_zero", r256, 256'd0);

    // WIDTH=256 randomized
    for (int n = 0; n < 4; n++) begin
      rm = rand256();
      rm[255] = 1'b1;
      ra = rand256() % rm;
      rb = rand256();
      prod = ({256'd0, ra} * {256'd0, rb}) % {256'd0, rm};
      op256(ra, rb, rm, r256, bc, dn);
      chk($sformatf("rnd256_%0d", n), r256, prod[255:0]);
      chk($sformatf("rnd256_%0d_done", n), 256'(dn), 256'd1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire
